// File: rtl/change_if.sv
// change_if: payout request, coin deposit, ejector handshake and status bundle of change_dispenser
interface change_if #(parameter int STOCK_W = 4);
  logic start;
  logic [15:0] credit, cost;
  logic deposit_valid;
  logic [1:0] deposit_coin;
  logic coin_valid;
  logic [1:0] coin_code;
  logic coin_ready;
  logic busy, done, insufficient, no_change, jam;
  logic [15:0] change_due;
  logic [STOCK_W-1:0] stock_500, stock_1000, stock_2000, stock_5000;
  modport master (
    output start, credit, cost, deposit_valid, deposit_coin, coin_ready,
    input coin_valid, coin_code, busy, done, insufficient, no_change, jam, change_due,
    input stock_500, stock_1000, stock_2000, stock_5000
  );
  modport slave (
    input start, credit, cost, deposit_valid, deposit_coin, coin_ready,
    output coin_valid, coin_code, busy, done, insufficient, no_change, jam, change_due,
    output stock_500, stock_1000, stock_2000, stock_5000
  );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: greedy change planner over a coin stock, ejecting one coin per handshake.
// Define CHANGE_TIMEOUT_EN to abort with a jam pulse after TIMEOUT_CYC stalled ejector cycles.
module change_dispenser #(
  parameter int STOCK_W     = 4,
  parameter int INIT_STOCK  = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input logic     CLK,
  input logic     RESET,
  change_if.slave bus
);
`ifdef CHANGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, CHECK, PLAN, DISPENSE, JAM} state_t;
  localparam logic [STOCK_W-1:0] SMAX  = '1;
  localparam logic [STOCK_W-1:0] S1    = STOCK_W'(1);
  localparam logic [STOCK_W-1:0] SINIT = STOCK_W'(INIT_STOCK);
  state_t state;
  logic [15:0] credit_q, cost_q, rem, rem_n, q, pk, cnt;
  logic [1:0] pidx, pcode, top;
  logic [STOCK_W-1:0] stock [4];
  logic [STOCK_W-1:0] snap [4];
  logic [STOCK_W-1:0] plan [4];
  logic [STOCK_W-1:0] plan_n [4];
  logic [STOCK_W-1:0] stock_n [4];
  logic [3:0] dep, out;
  logic xfer, any;
  function automatic logic [15:0] coin_val(input logic [1:0] c);
    return c == 2'd3 ? 16'd50 : c == 2'd2 ? 16'd20 : c == 2'd1 ? 16'd10 : 16'd5;
  endfunction
  assign xfer  = bus.coin_valid & bus.coin_ready;
  assign pcode = ~pidx;
  assign q     = pidx == 2'd0 ? rem / 16'd50 : pidx == 2'd1 ? rem / 16'd20 :
                 pidx == 2'd2 ? rem / 16'd10 : rem / 16'd5;
  assign pk    = q > 16'(snap[pcode]) ? 16'(snap[pcode]) : q;
  assign rem_n = rem - pk * coin_val(pcode);
  assign bus.busy       = state != IDLE;
  assign bus.stock_500  = stock[0];
  assign bus.stock_1000 = stock[1];
  assign bus.stock_2000 = stock[2];
  assign bus.stock_5000 = stock[3];
  // plan_n is the plan after this cycle's planning step or transfer; top picks its largest coin
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dep[i] = bus.deposit_valid && bus.deposit_coin == 2'(i);
      out[i] = xfer && bus.coin_code == 2'(i);
      plan_n[i] = state == PLAN && pcode == 2'(i) ? pk[STOCK_W-1:0] : out[i] ? plan[i] - S1 : plan[i];
      stock_n[i] = dep[i] == out[i] ? stock[i] : out[i] ? stock[i] - S1 :
                   stock[i] == SMAX ? stock[i] : stock[i] + S1;
    end
    top = plan_n[3] != '0 ? 2'd3 : plan_n[2] != '0 ? 2'd2 : plan_n[1] != '0 ? 2'd1 : 2'd0;
    any = (plan_n[0] | plan_n[1] | plan_n[2] | plan_n[3]) != '0;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      credit_q <= '0;
      cost_q <= '0;
      rem <= '0;
      pidx <= '0;
      cnt <= '0;
      for (int i = 0; i < 4; i++) begin
        stock[i] <= SINIT;
        snap[i] <= '0;
        plan[i] <= '0;
      end
      bus.coin_valid <= 1'b0;
      bus.coin_code <= 2'd0;
      bus.done <= 1'b0;
      bus.insufficient <= 1'b0;
      bus.no_change <= 1'b0;
      bus.jam <= 1'b0;
      bus.change_due <= '0;
    end else begin
      stock <= stock_n;
      bus.done <= 1'b0;
      bus.insufficient <= 1'b0;
      bus.no_change <= 1'b0;
      bus.jam <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          credit_q <= bus.credit;
          cost_q <= bus.cost;
          state <= CHECK;
        end
        CHECK: begin
          cnt <= '0;
          pidx <= '0;
          snap <= stock;
          rem <= credit_q - cost_q;
          if (credit_q < cost_q) begin
            bus.insufficient <= 1'b1;
            state <= IDLE;
          end else if (credit_q == cost_q) begin
            bus.done <= 1'b1;
            bus.change_due <= '0;
            state <= IDLE;
          end else begin
            bus.change_due <= credit_q - cost_q;
            state <= PLAN;
          end
        end
        PLAN: begin
          plan <= plan_n;
          rem <= rem_n;
          pidx <= pidx + 2'd1;
          if (pidx == 2'd3 && rem_n != '0) begin
            bus.no_change <= 1'b1;
            bus.change_due <= '0;
            state <= IDLE;
          end else if (pidx == 2'd3) begin
            bus.coin_valid <= 1'b1;
            bus.coin_code <= top;
            state <= DISPENSE;
          end
        end
        DISPENSE: if (xfer) begin
          plan <= plan_n;
          cnt <= '0;
          bus.change_due <= bus.change_due - coin_val(bus.coin_code);
          if (any) bus.coin_code <= top;
          else begin
            bus.coin_valid <= 1'b0;
            bus.done <= 1'b1;
            state <= IDLE;
          end
        end else if (TO_EN && cnt == 16'(TIMEOUT_CYC - 1)) begin
          bus.coin_valid <= 1'b0;
          state <= JAM;
        end else if (TO_EN) cnt <= cnt + 16'd1;
        JAM: begin
          bus.jam <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed payouts checked every cycle against a greedy-payout timeline model,
// plus literal spot checks; a second instance with empty stock covers the no-change case.
module tb_change_dispenser;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  change_if #(.STOCK_W(4)) bus ();
  change_if #(.STOCK_W(4)) bus2 ();
  change_dispenser #(.STOCK_W(4), .INIT_STOCK(5), .TIMEOUT_CYC(255)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus.slave));
  change_dispenser #(.STOCK_W(4), .INIT_STOCK(0), .TIMEOUT_CYC(255)) dut0 (
    .CLK(CLK), .RESET(RESET), .bus(bus2.slave));
  always #5 CLK = ~CLK;
  int checks = 0;
  int errors = 0;
  int jam_seen = 0;
  bit run = 0;
  int m_stock [4] = '{5, 5, 5, 5};
  int m_t = 0, m_c = 0, m_k = 0, m_due = 0, m_stall = 0, m_rem = 0;
  int m_q [$];
  logic e_valid = 0, e_done = 0, e_ins = 0, e_nc = 0, e_jam = 0;
  logic [1:0] e_code = 0;
  function automatic int val(int c);
    return c == 3 ? 50 : c == 2 ? 20 : c == 1 ? 10 : 5;
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick(int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic go(int c, int k);
    bus.credit = 16'(c);
    bus.cost = 16'(k);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  // m_t counts the payout timeline: 1 check, 2..5 planning, 6 ejecting, 7 jam
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_t = 0;
      m_due = 0;
      m_stall = 0;
      m_q.delete();
      e_valid = 0; e_code = 0; e_done = 0; e_ins = 0; e_nc = 0; e_jam = 0;
      foreach (m_stock[i]) m_stock[i] = 5;
    end else begin
      bit xf;
      int xc;
      int snap [4];
      xf = e_valid && bus.coin_ready;
      xc = int'(e_code);
      snap = m_stock;
      e_done = 0; e_ins = 0; e_nc = 0; e_jam = 0;
      for (int i = 0; i < 4; i++) begin
        bit d, o;
        d = bus.deposit_valid && bus.deposit_coin == 2'(i);
        o = xf && xc == i;
        if (o && !d) m_stock[i]--;
        else if (d && !o && m_stock[i] < 15) m_stock[i]++;
      end
      case (m_t)
        0: if (bus.start) begin
          m_c = int'(bus.credit);
          m_k = int'(bus.cost);
          m_t = 1;
        end
        1: if (m_c < m_k) begin
          e_ins = 1; m_t = 0;
        end else if (m_c == m_k) begin
          e_done = 1; m_due = 0; m_t = 0;
        end else begin
          m_due = m_c - m_k;
          m_rem = m_due;
          m_q.delete();
          for (int c = 3; c >= 0; c--) begin
            int n;
            n = m_rem / val(c);
            if (n > snap[c]) n = snap[c];
            m_rem -= n * val(c);
            repeat (n) m_q.push_back(c);
          end
          m_t = 2;
        end
        2, 3, 4: m_t++;
        5: if (m_rem != 0) begin
          e_nc = 1; m_due = 0; m_t = 0;
        end else begin
          e_valid = 1; e_code = 2'(m_q[0]); m_stall = 0; m_t = 6;
        end
        6: if (xf) begin
          m_due -= val(xc);
          void'(m_q.pop_front());
          m_stall = 0;
          if (m_q.size() == 0) begin
            e_valid = 0; e_done = 1; m_t = 0;
          end else e_code = 2'(m_q[0]);
        end else begin
          m_stall++;
`ifdef CHANGE_TIMEOUT_EN
          if (m_stall == 255) begin
            e_valid = 0; m_t = 7;
          end
`endif
        end
        7: begin
          e_jam = 1; m_t = 0;
        end
        default: m_t = 0;
      endcase
    end
  end
  always @(negedge CLK) if (run && !RESET) begin
    chk("coin_valid", int'(bus.coin_valid), int'(e_valid));
    if (e_valid) chk("coin_code", int'(bus.coin_code), int'(e_code));
    chk("busy", int'(bus.busy), int'(m_t != 0));
    chk("done", int'(bus.done), int'(e_done));
    chk("insufficient", int'(bus.insufficient), int'(e_ins));
    chk("no_change", int'(bus.no_change), int'(e_nc));
    chk("jam", int'(bus.jam), int'(e_jam));
    chk("change_due", int'(bus.change_due), m_due);
    chk("stock_500", int'(bus.stock_500), m_stock[0]);
    chk("stock_1000", int'(bus.stock_1000), m_stock[1]);
    chk("stock_2000", int'(bus.stock_2000), m_stock[2]);
    chk("stock_5000", int'(bus.stock_5000), m_stock[3]);
    if (bus.jam) jam_seen++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t expected finish", $time);
    $fatal(1);
  end
  initial begin
    bus.start = 0; bus.credit = 0; bus.cost = 0; bus.deposit_valid = 0; bus.deposit_coin = 0;
    bus.coin_ready = 1;
    bus2.start = 0; bus2.credit = 0; bus2.cost = 0; bus2.deposit_valid = 0; bus2.deposit_coin = 0;
    bus2.coin_ready = 0;
    tick(2);
    chk("rst_valid", int'(bus.coin_valid), 0);
    chk("rst_code", int'(bus.coin_code), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_due", int'(bus.change_due), 0);
    chk("rst_stock_500", int'(bus.stock_500), 5);
    chk("rst_stock_5000", int'(bus.stock_5000), 5);
    RESET = 0;
    run = 1;
    tick();
    // 85-15=70 pays 50 then 20
    go(85, 15);
    tick(5);
    chk("t1_valid", int'(bus.coin_valid), 1);
    chk("t1_code_first", int'(bus.coin_code), 3);
    tick();
    chk("t1_code_second", int'(bus.coin_code), 2);
    chk("t1_stock_5000", int'(bus.stock_5000), 4);
    tick();
    chk("t1_done", int'(bus.done), 1);
    chk("t1_stock_2000", int'(bus.stock_2000), 4);
    chk("t1_due", int'(bus.change_due), 0);
    go(10, 15);
    tick();
    chk("t2_insufficient", int'(bus.insufficient), 1);
    tick(3);
    chk("t2_stock_5000", int'(bus.stock_5000), 4);
    go(30, 30);
    tick();
    chk("t3_done", int'(bus.done), 1);
    chk("t3_due", int'(bus.change_due), 0);
    tick(2);
    // ejector stalls three cycles on a single 1000 coin
    bus.coin_ready = 0;
    go(25, 15);
    tick(5);
    for (int i = 0; i < 4; i++) begin
      chk("t4_code_hold", int'(bus.coin_code), 1);
      chk("t4_valid_hold", int'(bus.coin_valid), 1);
      chk("t4_due_hold", int'(bus.change_due), 10);
      if (i == 3) bus.coin_ready = 1;
      tick();
    end
    chk("t4_done", int'(bus.done), 1);
    chk("t4_due", int'(bus.change_due), 0);
    chk("t4_stock_1000", int'(bus.stock_1000), 4);
    bus.deposit_coin = 2;
    bus.deposit_valid = 1;
    tick(12);
    bus.deposit_valid = 0;
    chk("sat_stock_2000", int'(bus.stock_2000), 15);
    go(3, 0);
    tick(4);
    chk("nc_early", int'(bus.no_change), 0);
    tick();
    chk("nc_pulse", int'(bus.no_change), 1);
    chk("nc_due", int'(bus.change_due), 0);
    tick(2);
    // deposit a 5000 while a 5000 is ejected
    go(55, 0);
    tick(5);
    chk("dx_code", int'(bus.coin_code), 3);
    bus.deposit_coin = 3;
    bus.deposit_valid = 1;
    tick();
    bus.deposit_valid = 0;
    chk("dx_stock_5000", int'(bus.stock_5000), 4);
    chk("dx_code_next", int'(bus.coin_code), 0);
    tick();
    chk("dx_done", int'(bus.done), 1);
    chk("dx_stock_500", int'(bus.stock_500), 4);
    tick();
    bus.coin_ready = 0;
    go(20, 15);
    tick(305);
`ifdef CHANGE_TIMEOUT_EN
    chk("stall_jam_count", jam_seen, 1);
`else
    chk("stall_jam_count", jam_seen, 0);
`endif
    bus.coin_ready = 1;
    tick(3);
    bus.coin_ready = 0;
    go(100, 0);
    tick(6);
    chk("rst_mid_valid_before", int'(bus.coin_valid), 1);
    RESET = 1;
    #1;
    chk("rst_mid_valid", int'(bus.coin_valid), 0);
    chk("rst_mid_stock_5000", int'(bus.stock_5000), 5);
    chk("rst_mid_busy", int'(bus.busy), 0);
    tick();
    RESET = 0;
    bus.coin_ready = 1;
    tick();
    go(85, 15);
    tick(5);
    chk("post_rst_code", int'(bus.coin_code), 3);
    tick(3);
    chk("post_rst_stock_5000", int'(bus.stock_5000), 4);
    bus2.deposit_coin = 1;
    bus2.deposit_valid = 1;
    tick();
    bus2.deposit_valid = 0;
    chk("e0_stock_1000", int'(bus2.stock_1000), 1);
    bus2.credit = 20;
    bus2.cost = 15;
    bus2.start = 1;
    tick();
    bus2.start = 0;
    tick(4);
    chk("e0_nc_early", int'(bus2.no_change), 0);
    tick();
    chk("e0_nc_pulse", int'(bus2.no_change), 1);
    chk("e0_valid", int'(bus2.coin_valid), 0);
    chk("e0_stock_1000_kept", int'(bus2.stock_1000), 1);
    tick();
    chk("e0_idle", int'(bus2.busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
